// File: rtl/wb_conbus_slv_dec_pkg.sv
`default_nettype none
// wb_conbus_pkg: shared types and helpers for the wb_conbus slave-side decoder.
package wb_conbus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    ERR    = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_UNMAPPED = 2'd0,
    CAUSE_TIMEOUT  = 2'd1,
    CAUSE_SLVERR   = 2'd2
  } err_cause_t;

  // Width of the slave index taken from the top address bits.
  function automatic int idx_width(input int num_slaves);
    return (num_slaves <= 2) ? 1 : $clog2(num_slaves);
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_conbus_slv_dec_to_cnt.sv
`default_nettype none
// wb_conbus_to_cnt: saturating timeout counter; hit flags the increment that reaches TIMEOUT.
module wb_conbus_to_cnt #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic hit
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != LIMIT)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Combinational so that a response in the same cycle can still override it.
  assign hit = inc && (cnt == (LIMIT - 1'b1));

endmodule
`default_nettype wire

// File: rtl/wb_conbus_slv_dec.sv
`default_nettype none
// wb_conbus_slv_dec: decodes the granted master onto NUM_SLAVES slaves and routes responses back.
// Optional sticky error log enabled by WB_CONBUS_ERR_LOG_EN.
module wb_conbus_slv_dec
  import wb_conbus_pkg::*;
#(
  parameter int                    NUM_SLAVES = 8,
  parameter int                    AW         = 32,
  parameter int                    DW         = 32,
  parameter logic [NUM_SLAVES-1:0] SLV_MASK   = '1,
  parameter int                    TIMEOUT    = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [AW-1:0]            m_adr_i,
  input  logic [DW-1:0]            m_dat_i,
  input  logic [DW/8-1:0]          m_sel_i,
  input  logic                     m_we_i,
  input  logic                     m_cyc_i,
  input  logic                     m_stb_i,
  output logic [DW-1:0]            m_dat_o,
  output logic                     m_ack_o,
  output logic                     m_err_o,
  output logic                     m_rty_o,
  output logic [AW-1:0]            s_adr_o,
  output logic [DW-1:0]            s_dat_o,
  output logic [DW/8-1:0]          s_sel_o,
  output logic                     s_we_o,
  output logic [NUM_SLAVES-1:0]    s_cyc_o,
  output logic [NUM_SLAVES-1:0]    s_stb_o,
  input  logic [NUM_SLAVES*DW-1:0] s_dat_i,
  input  logic [NUM_SLAVES-1:0]    s_ack_i,
  input  logic [NUM_SLAVES-1:0]    s_err_i,
  input  logic [NUM_SLAVES-1:0]    s_rty_i
`ifdef WB_CONBUS_ERR_LOG_EN
  ,
  input  logic                     err_clr_i,
  output logic                     err_valid_o,
  output logic [AW-1:0]            err_adr_o,
  output logic [1:0]               err_cause_o
`endif
);

  localparam int IW = idx_width(NUM_SLAVES);

  state_t        state;
  state_t        state_nxt;
  logic [IW-1:0] idx;
  logic [IW-1:0] sel_q;
  logic          req;
  logic          sel_ack;
  logic          sel_err;
  logic          sel_rty;
  logic          resp;
  logic          to_clr;
  logic          to_inc;
  logic          to_hit;

  assign idx     = m_adr_i[AW-1 -: IW];
  assign req     = m_cyc_i & m_stb_i;
  assign sel_ack = s_ack_i[sel_q];
  assign sel_err = s_err_i[sel_q];
  assign sel_rty = s_rty_i[sel_q];
  assign resp    = sel_ack | sel_err | sel_rty;

  assign s_adr_o = m_adr_i;
  assign s_dat_o = m_dat_i;
  assign s_sel_o = m_sel_i;
  assign s_we_o  = m_we_i;

  assign to_clr = (state != ACTIVE);
  assign to_inc = (state == ACTIVE) & m_cyc_i & ~resp;

  wb_conbus_to_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_to_cnt (
    .clk (clk),
    .rst (rst),
    .clr (to_clr),
    .inc (to_inc),
    .hit (to_hit)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      sel_q <= '0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && req) begin
        sel_q <= idx;
      end
    end
  end

  // Abort beats response beats timeout, so a late ack never turns into an err.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req) begin
          state_nxt = SLV_MASK[idx] ? ACTIVE : ERR;
        end
      end
      ACTIVE: begin
        if (!m_cyc_i || resp) begin
          state_nxt = IDLE;
        end else if (to_hit) begin
          state_nxt = ERR;
        end
      end
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_cyc_o = '0;
    s_stb_o = '0;
    m_dat_o = '0;
    m_ack_o = 1'b0;
    m_err_o = 1'b0;
    m_rty_o = 1'b0;
    case (state)
      ACTIVE: begin
        s_cyc_o[sel_q] = m_cyc_i;
        s_stb_o[sel_q] = m_stb_i;
        m_dat_o        = m_stb_i ? s_dat_i[sel_q*DW +: DW] : '0;
        m_ack_o        = m_stb_i & sel_ack;
        m_err_o        = m_stb_i & sel_err;
        m_rty_o        = m_stb_i & sel_rty;
      end
      ERR:     m_err_o = 1'b1;
      default: ;
    endcase
  end

`ifdef WB_CONBUS_ERR_LOG_EN
  logic       to_err_q;
  err_cause_t cause;

  // Remembers whether ERR was entered from ACTIVE (timeout) or IDLE (unmapped).
  always_ff @(posedge clk) begin
    if (!rst) begin
      to_err_q <= 1'b0;
    end else if (state_nxt == ERR) begin
      to_err_q <= (state == ACTIVE);
    end
  end

  always_comb begin
    cause = CAUSE_SLVERR;
    if (state == ERR) begin
      cause = to_err_q ? CAUSE_TIMEOUT : CAUSE_UNMAPPED;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      err_valid_o <= 1'b0;
      err_adr_o   <= '0;
      err_cause_o <= '0;
    end else if (m_err_o && (!err_valid_o || err_clr_i)) begin
      err_valid_o <= 1'b1;
      err_adr_o   <= m_adr_i;
      err_cause_o <= cause;
    end else if (err_clr_i) begin
      err_valid_o <= 1'b0;
      err_adr_o   <= '0;
      err_cause_o <= '0;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_conbus_slv_dec.sv
`default_nettype none
// Directed self-checking bench for wb_conbus_slv_dec (SLV_MASK=8'h7F, TIMEOUT=4).
module tb_wb_conbus_slv_dec;

  localparam int NS = 8;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [AW-1:0]   m_adr_i;
  logic [DW-1:0]   m_dat_i;
  logic [DW/8-1:0] m_sel_i;
  logic            m_we_i;
  logic            m_cyc_i;
  logic            m_stb_i;
  logic [DW-1:0]   m_dat_o;
  logic            m_ack_o;
  logic            m_err_o;
  logic            m_rty_o;
  logic [AW-1:0]   s_adr_o;
  logic [DW-1:0]   s_dat_o;
  logic [DW/8-1:0] s_sel_o;
  logic            s_we_o;
  logic [NS-1:0]   s_cyc_o;
  logic [NS-1:0]   s_stb_o;
  logic [NS*DW-1:0] s_dat_i;
  logic [NS-1:0]   s_ack_i;
  logic [NS-1:0]   s_err_i;
  logic [NS-1:0]   s_rty_i;
`ifdef WB_CONBUS_ERR_LOG_EN
  logic            err_clr_i;
  logic            err_valid_o;
  logic [AW-1:0]   err_adr_o;
  logic [1:0]      err_cause_o;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_conbus_slv_dec #(
    .NUM_SLAVES (NS),
    .AW         (AW),
    .DW         (DW),
    .SLV_MASK   (8'h7F),
    .TIMEOUT    (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .m_adr_i     (m_adr_i),
    .m_dat_i     (m_dat_i),
    .m_sel_i     (m_sel_i),
    .m_we_i      (m_we_i),
    .m_cyc_i     (m_cyc_i),
    .m_stb_i     (m_stb_i),
    .m_dat_o     (m_dat_o),
    .m_ack_o     (m_ack_o),
    .m_err_o     (m_err_o),
    .m_rty_o     (m_rty_o),
    .s_adr_o     (s_adr_o),
    .s_dat_o     (s_dat_o),
    .s_sel_o     (s_sel_o),
    .s_we_o      (s_we_o),
    .s_cyc_o     (s_cyc_o),
    .s_stb_o     (s_stb_o),
    .s_dat_i     (s_dat_i),
    .s_ack_i     (s_ack_i),
    .s_err_i     (s_err_i),
    .s_rty_i     (s_rty_i)
`ifdef WB_CONBUS_ERR_LOG_EN
    ,
    .err_clr_i   (err_clr_i),
    .err_valid_o (err_valid_o),
    .err_adr_o   (err_adr_o),
    .err_cause_o (err_cause_o)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are then driven and checked.
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic master(input logic [AW-1:0] a, input logic c, input logic s);
    m_adr_i = a;
    m_cyc_i = c;
    m_stb_i = s;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    master('0, 1'b0, 1'b0);
    m_dat_i = '0; m_sel_i = '0; m_we_i = 1'b0;
    s_dat_i = '0; s_ack_i = '0; s_err_i = '0; s_rty_i = '0;
`ifdef WB_CONBUS_ERR_LOG_EN
    err_clr_i = 1'b0;
`endif
    next(); next();
    #1;
    chk("rst s_cyc", s_cyc_o, 8'h00);
    chk("rst s_stb", s_stb_o, 8'h00);
    chk("rst m_ack", m_ack_o, 1'b0);
    chk("rst m_err", m_err_o, 1'b0);
    chk("rst m_dat", m_dat_o, 32'h0);
    rst = 1'b1;

    // Read from slave 2, ack in the 4th ACTIVE cycle (counter at TIMEOUT-1: ack wins)
    next();
    master(32'h4000_0010, 1'b1, 1'b1);
    m_sel_i = 4'hF;
    s_dat_i[2*DW +: DW] = 32'hDEAD_BEEF;
    #1;
    chk("rd c0 s_stb", s_stb_o, 8'h00);
    chk("rd c0 s_adr", s_adr_o, 32'h4000_0010);
    next(); #1;
    chk("rd c1 s_stb", s_stb_o, 8'h04);
    chk("rd c1 s_cyc", s_cyc_o, 8'h04);
    chk("rd c1 m_ack", m_ack_o, 1'b0);
    next(); next(); #1;
    chk("rd c3 s_stb", s_stb_o, 8'h04);
    next();
    s_ack_i = 8'h04;
    #1;
    chk("rd c4 m_ack", m_ack_o, 1'b1);
    chk("rd c4 m_dat", m_dat_o, 32'hDEAD_BEEF);
    chk("rd c4 m_err", m_err_o, 1'b0);
    next();
    s_ack_i = 8'h00;
    #1;
    chk("rd c5 idle s_stb", s_stb_o, 8'h00);
    chk("rd c5 m_err", m_err_o, 1'b0);
    next(); #1;
    chk("b2b c6 s_stb", s_stb_o, 8'h04);
    s_ack_i = 8'h04;
    #1;
    chk("b2b c6 m_ack", m_ack_o, 1'b1);
    next();
    master('0, 1'b0, 1'b0);
    s_ack_i = 8'h00;

    // Unmapped slave 7
    master(32'hE000_0000, 1'b1, 1'b1);
    #1;
    chk("unm c0 s_stb", s_stb_o, 8'h00);
    next(); #1;
    chk("unm c1 m_err", m_err_o, 1'b1);
    chk("unm c1 s_stb", s_stb_o, 8'h00);
    chk("unm c1 m_dat", m_dat_o, 32'h0);
    next();
    master('0, 1'b0, 1'b0);
    #1;
    chk("unm c2 m_err", m_err_o, 1'b0);
`ifdef WB_CONBUS_ERR_LOG_EN
    chk("log unm valid", err_valid_o, 1'b1);
    chk("log unm cause", err_cause_o, 2'd0);
    chk("log unm adr", err_adr_o, 32'hE000_0000);
`endif

    // Timeout on slave 3, which never responds
    next();
    master(32'h6000_0000, 1'b1, 1'b1);
    #1;
    chk("to c0 s_stb", s_stb_o, 8'h00);
    for (int i = 1; i <= 4; i++) begin
      next(); #1;
      chk($sformatf("to c%0d s_stb", i), s_stb_o, 8'h08);
      chk($sformatf("to c%0d m_err", i), m_err_o, 1'b0);
    end
    next(); #1;
    chk("to c5 s_stb", s_stb_o, 8'h00);
    chk("to c5 s_cyc", s_cyc_o, 8'h00);
    chk("to c5 m_err", m_err_o, 1'b1);
    next();
    master('0, 1'b0, 1'b0);
    #1;
    chk("to c6 m_err", m_err_o, 1'b0);
`ifdef WB_CONBUS_ERR_LOG_EN
    chk("log first held", err_cause_o, 2'd0);
    err_clr_i = 1'b1;
    next();
    err_clr_i = 1'b0;
    #1;
    chk("log clr valid", err_valid_o, 1'b0);
`endif

    // Stray ack from slave 5 while slave 1 is selected; write pass-through
    next();
    master(32'h2000_0000, 1'b1, 1'b1);
    m_we_i  = 1'b1;
    m_dat_i = 32'hA5A5_5A5A;
    s_dat_i[1*DW +: DW] = 32'h1111_1111;
    s_dat_i[5*DW +: DW] = 32'h5555_5555;
    #1;
    chk("wr s_we", s_we_o, 1'b1);
    chk("wr s_dat", s_dat_o, 32'hA5A5_5A5A);
    next();
    s_ack_i = 8'h20;
    #1;
    chk("stray m_ack", m_ack_o, 1'b0);
    chk("stray m_dat", m_dat_o, 32'h1111_1111);
    next();
    s_ack_i = 8'h22;
    #1;
    chk("sel1 m_ack", m_ack_o, 1'b1);
    next();
    master('0, 1'b0, 1'b0);
    m_we_i  = 1'b0;
    s_ack_i = 8'h00;

    // Slave 1 returns err and rty together
    next();
    master(32'h2000_0000, 1'b1, 1'b1);
    #1;
    next();
    s_err_i = 8'h02;
    s_rty_i = 8'h02;
    #1;
    chk("slverr m_err", m_err_o, 1'b1);
    chk("slverr m_rty", m_rty_o, 1'b1);
    chk("slverr m_ack", m_ack_o, 1'b0);
    next();
    master('0, 1'b0, 1'b0);
    s_err_i = 8'h00;
    s_rty_i = 8'h00;
    #1;
`ifdef WB_CONBUS_ERR_LOG_EN
    chk("log slverr cause", err_cause_o, 2'd2);
    chk("log slverr adr", err_adr_o, 32'h2000_0000);
`endif

    // Reset during ACTIVE on slave 4
    next();
    master(32'h8000_0000, 1'b1, 1'b1);
    #1;
    next(); #1;
    chk("rstx c1 s_stb", s_stb_o, 8'h10);
    rst = 1'b0;
    next();
    s_ack_i = 8'h10;
    #1;
    chk("rstx s_stb", s_stb_o, 8'h00);
    chk("rstx s_cyc", s_cyc_o, 8'h00);
    chk("rstx m_ack", m_ack_o, 1'b0);
    chk("rstx m_err", m_err_o, 1'b0);
`ifdef WB_CONBUS_ERR_LOG_EN
    chk("rstx log valid", err_valid_o, 1'b0);
`endif
    s_ack_i = 8'h00;
    next();
    rst = 1'b1;
    #1;
    chk("rstx idle s_stb", s_stb_o, 8'h00);
    next(); #1;
    chk("post-rst s_stb", s_stb_o, 8'h10);
    s_ack_i = 8'h10;
    #1;
    chk("post-rst m_ack", m_ack_o, 1'b1);
    next();
    master('0, 1'b0, 1'b0);
    s_ack_i = 8'h00;
    next();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
